// File: rtl/smart_counter_pro.sv
// Parametrised up/down event counter with programmable limit, wrap/saturate,
// enable prescaler and a registered terminal-count pulse.
module smart_counter_pro #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_bound
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  localparam logic [PW-1:0]    PRE_MAX = PW'(DIV - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             step;

  assign at_bound = up ? (cnt_q >= limit) : (cnt_q == '0);
  // DIV==1 makes the prescaler compare constant-true so the register folds away
  assign step     = enable && ((DIV == 1) || (pre_q == PRE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    tc_d  = 1'b0;
    if (clr) begin
      cnt_d = RST_Q;
      pre_d = '0;
    end else if (load) begin
      cnt_d = (load_val > limit) ? limit : load_val;
      pre_d = '0;
    end else if (enable) begin
      pre_d = step ? '0 : pre_q + PW'(1);
      if (step) begin
        tc_d = at_bound;
        if (up) begin
          if (cnt_q < limit) cnt_d = cnt_q + WIDTH'(1);
          else               cnt_d = sat_mode ? limit : '0;
        end else begin
          if (cnt_q != '0)   cnt_d = cnt_q - WIDTH'(1);
          else               cnt_d = sat_mode ? '0 : limit;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= RST_Q;
      pre_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= (DIV == 1) ? '0 : pre_d;
      tc_q  <= tc_d;
    end
  end

  assign q  = cnt_q;
  assign tc = tc_q;

endmodule
